// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO: any depth >= 2, programmable almost thresholds,
// occupancy count and selectable registered or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic                                rd_en,
  input  logic [FIFO_WIDTH-1:0]               data_in,
  output logic [FIFO_WIDTH-1:0]               data_out,
  output logic                                wr_ack,
  output logic                                overflow,
  output logic                                underflow,
  output logic                                full,
  output logic                                empty,
  output logic                                almostfull,
  output logic                                almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          wr_ack_reg, overflow_reg, underflow_reg;
  logic          rd_ok, wr_ok;

  assign full        = (count_reg == CW'(FIFO_DEPTH));
  assign empty       = (count_reg == '0);
  assign almostfull  = (count_reg >= CW'(AF_LEVEL)) && !full;
  assign almostempty = !empty && (count_reg <= CW'(AE_LEVEL));
  assign count       = count_reg;

  // A read on a full FIFO frees the slot the simultaneous write lands in.
  assign rd_ok = rd_en && !empty;
  assign wr_ok = wr_en && (!full || rd_ok);

  // Depth need not be a power of two, so wrap on an explicit compare.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_ok) wr_ptr_next = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
    if (rd_ok) rd_ptr_next = (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + 1'b1;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wr_ack_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      wr_ack_reg    <= wr_ok;
      overflow_reg  <= wr_en && !wr_ok;
      underflow_reg <= rd_en && !rd_ok;
    end
  end

  // Storage is never cleared; reset only discards the pending write.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[wr_ptr_reg] <= data_in;
  end

  assign wr_ack    = wr_ack_reg;
  assign overflow  = overflow_reg;
  assign underflow = underflow_reg;

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[rd_ptr_reg];
    end else begin : g_reg_read
      logic [FIFO_WIDTH-1:0] data_out_reg;
      always_ff @(posedge clk) begin
        if (rst)        data_out_reg <= '0;
        else if (rd_ok) data_out_reg <= mem[rd_ptr_reg];
      end
      assign data_out = data_out_reg;
    end
  endgenerate

endmodule
